// File: rtl/clock_speed_ctrl.sv
// -----------------------------------------------------------------------------
// clock_speed_ctrl
//
// Sequences a run-time change of the CPU clock speed select. An asynchronous
// speed request is synchronized and debounced; once it differs from the
// current SPEED, the block waits for the 68030 bus to go idle. It then raises
// HOLD so no new bus cycle starts, drains any cycle that slipped through the
// synchronizer, flips SPEED, lets the clock generator settle and releases HOLD.
//
// Ports (all in the CLK100M domain):
//   CLK100M    in   sole clock, rising edge
//   RESET      in   asynchronous reset, active low
//   SPEED_REQ  in   asynchronous requested speed (1 = fast, 0 = slow)
//   AS30       in   asynchronous CPU address strobe, active low
//   SPEED      out  registered speed select to the clock generator
//   HOLD       out  registered; 1 = do not start a new CPU bus cycle
//   BUSY       out  registered; 1 = a switch sequence is in progress
// -----------------------------------------------------------------------------
module clock_speed_ctrl #(
   parameter int DEBOUNCE    = 1024,
   parameter int IDLE_CYCLES = 4,
   parameter int SETTLE      = 64
) (
   input  logic CLK100M,
   input  logic RESET,
   input  logic SPEED_REQ,
   input  logic AS30,
   output logic SPEED,
   output logic HOLD,
   output logic BUSY
);

   localparam int DRAIN_CYCLES = 3;
   localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int SEQ_A   = (IDLE_CYCLES > SETTLE) ? IDLE_CYCLES : SETTLE;
   localparam int SEQ_MAX = (SEQ_A > DRAIN_CYCLES) ? SEQ_A : DRAIN_CYCLES;
   localparam int SQ_W    = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE - 1);
   localparam logic [SQ_W-1:0] IDLE_LAST   = SQ_W'(IDLE_CYCLES - 1);
   localparam logic [SQ_W-1:0] DRAIN_LAST  = SQ_W'(DRAIN_CYCLES - 1);
   localparam logic [SQ_W-1:0] SETTLE_LAST = SQ_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_DRAIN,
      S_SWITCH,
      S_SETTLE,
      S_RELEASE
   } state_t;

   logic            req_p0;
   logic            req_sync;
   logic            as_p0;
   logic            as_sync;
   logic [DB_W-1:0] db_cnt;
   logic            req_stable;
   state_t          state;
   logic [SQ_W-1:0] seq_cnt;

   // Stage p0 -> sync: two-flop synchronizers. AS30 resets high (bus idle).
   always_ff @(posedge CLK100M or negedge RESET) begin
      if (!RESET) begin
         req_p0   <= 1'b0;
         req_sync <= 1'b0;
         as_p0    <= 1'b1;
         as_sync  <= 1'b1;
      end else begin
         req_p0   <= SPEED_REQ;
         req_sync <= req_p0;
         as_p0    <= AS30;
         as_sync  <= as_p0;
      end
   end

   // Debounce: req_p0 is the value req_sync takes next, so a mismatch marks
   // the edge on which req_sync changes and restarts the run. db_cnt then
   // holds (cycles held - 1) and saturates at DEBOUNCE-1, where the held
   // value is accepted.
   always_ff @(posedge CLK100M or negedge RESET) begin
      if (!RESET) begin
         db_cnt     <= '0;
         req_stable <= 1'b0;
      end else if (req_p0 != req_sync) begin
         db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
         db_cnt <= db_cnt + 1'b1;
      end else begin
         req_stable <= req_sync;
      end
   end

   // Switch sequencer. One counter serves the idle, drain and settle waits
   // since only one of them is active at a time.
   always_ff @(posedge CLK100M or negedge RESET) begin
      if (!RESET) begin
         state   <= S_IDLE;
         seq_cnt <= '0;
         SPEED   <= 1'b0;
         HOLD    <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               HOLD    <= 1'b0;
               BUSY    <= 1'b0;
               seq_cnt <= '0;
               if (req_stable != SPEED) begin
                  BUSY  <= 1'b1;
                  state <= S_WAIT_IDLE;
               end
            end

            // Abort has priority over completing the idle count.
            S_WAIT_IDLE: begin
               if (req_stable == SPEED) begin
                  BUSY    <= 1'b0;
                  seq_cnt <= '0;
                  state   <= S_IDLE;
               end else if (!as_sync) begin
                  seq_cnt <= '0;
               end else if (seq_cnt == IDLE_LAST) begin
                  seq_cnt <= '0;
                  HOLD    <= 1'b1;
                  state   <= S_DRAIN;
               end else begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end

            // A CPU cycle may have started while HOLD was still in flight;
            // wait until the synchronized strobe is quiet again.
            S_DRAIN: begin
               if (!as_sync) begin
                  seq_cnt <= '0;
               end else if (seq_cnt == DRAIN_LAST) begin
                  seq_cnt <= '0;
                  state   <= S_SWITCH;
               end else begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end

            S_SWITCH: begin
               SPEED   <= req_stable;
               seq_cnt <= '0;
               state   <= S_SETTLE;
            end

            S_SETTLE: begin
               if (seq_cnt == SETTLE_LAST) begin
                  seq_cnt <= '0;
                  state   <= S_RELEASE;
               end else begin
                  seq_cnt <= seq_cnt + 1'b1;
               end
            end

            S_RELEASE: begin
               HOLD  <= 1'b0;
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               seq_cnt <= '0;
               HOLD    <= 1'b0;
               BUSY    <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
